// File: rtl/bus_fill_dma.sv
// Bus-master fill engine: muxes the CPU bus with a constant-word write stream
// onto the decoder bus, stalling the CPU while a fill run is in progress.
module bus_fill_dma #(
    parameter int LEN_WIDTH = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len_words,
    input  logic [31:0]          fill_data,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [LEN_WIDTH-1:0] words_done,
    input  logic [31:0]          cpu_bus_addr,
    input  logic [31:0]          cpu_bus_wr_data,
    input  logic                 cpu_bus_wr_en,
    output logic [31:0]          cpu_bus_rd_data,
    output logic                 cpu_stall,
    output logic [31:0]          bus_addr,
    output logic [31:0]          bus_wr_data,
    output logic                 bus_wr_en,
    input  logic [31:0]          bus_rd_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [31:0]          cur_addr;
    logic [31:0]          data_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_inc;

    assign cnt_inc = words_done + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            data_q     <= '0;
            len_q      <= '0;
            words_done <= '0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr   <= dst_addr;
                        data_q     <= fill_data;
                        len_q      <= len_words;
                        words_done <= '0;
                        aborted    <= 1'b0;
                        state      <= (len_words == '0) ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    cur_addr   <= cur_addr + 32'(ADDR_STEP);
                    words_done <= cnt_inc;
                    // Normal completion on the same edge takes priority over abort.
                    if (cnt_inc == len_q) begin
                        state <= ST_DONE;
                    end else if (abort) begin
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_FILL);
    assign done      = (state == ST_DONE);
    assign cpu_stall = busy;

    always_comb begin
        bus_addr        = cpu_bus_addr;
        bus_wr_data     = cpu_bus_wr_data;
        bus_wr_en       = cpu_bus_wr_en;
        cpu_bus_rd_data = bus_rd_data;
        if (busy) begin
            bus_addr        = cur_addr;
            bus_wr_data     = data_q;
            bus_wr_en       = 1'b1;
            cpu_bus_rd_data = '0;
        end
    end

endmodule

// File: tb/tb_bus_fill_dma.sv
// Directed self-checking bench for bus_fill_dma.
module tb_bus_fill_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic [31:0] fill_data;
    logic        abort;
    logic        busy, done, aborted;
    logic [15:0] words_done;
    logic [31:0] cpu_bus_addr, cpu_bus_wr_data, cpu_bus_rd_data;
    logic        cpu_bus_wr_en, cpu_stall;
    logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
    logic        bus_wr_en;

    int checks   = 0;
    int failures = 0;
    int writes;

    always #5 clk = ~clk;

    bus_fill_dma #(.LEN_WIDTH(16), .ADDR_STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr),
        .len_words(len_words), .fill_data(fill_data), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
        .cpu_bus_addr(cpu_bus_addr), .cpu_bus_wr_data(cpu_bus_wr_data),
        .cpu_bus_wr_en(cpu_bus_wr_en), .cpu_bus_rd_data(cpu_bus_rd_data),
        .cpu_stall(cpu_stall), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_wr_en(bus_wr_en), .bus_rd_data(bus_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] n, input logic [31:0] d);
        start     = 1'b1;
        dst_addr  = a;
        len_words = n;
        fill_data = d;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        dst_addr = '0; len_words = '0; fill_data = '0;
        cpu_bus_addr = '0; cpu_bus_wr_data = '0; cpu_bus_wr_en = 1'b0;
        bus_rd_data = 32'hCAFE0001;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_aborted", {31'b0, aborted}, 32'd0);
        check("rst_words", {16'b0, words_done}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // 1: pass-through
        cpu_bus_addr = 32'h10; cpu_bus_wr_data = 32'hAB; cpu_bus_wr_en = 1'b1;
        #1;
        check("pt_addr", bus_addr, 32'h10);
        check("pt_data", bus_wr_data, 32'hAB);
        check("pt_wen", {31'b0, bus_wr_en}, 32'd1);
        check("pt_stall", {31'b0, cpu_stall}, 32'd0);
        check("pt_rd0", cpu_bus_rd_data, 32'hCAFE0001);
        bus_rd_data = 32'h12345678;
        #1;
        check("pt_rd1", cpu_bus_rd_data, 32'h12345678);

        // 2: three-word fill, CPU writes held off the bus
        tick();
        cpu_bus_addr = 32'hDEAD0000; cpu_bus_wr_data = 32'h55; cpu_bus_wr_en = 1'b1;
        do_start(32'h20000, 16'd3, 32'h11223344);
        check("f_addr0", bus_addr, 32'h20000);
        check("f_data0", bus_wr_data, 32'h11223344);
        check("f_wen0", {31'b0, bus_wr_en}, 32'd1);
        check("f_busy", {31'b0, busy}, 32'd1);
        check("f_stall", {31'b0, cpu_stall}, 32'd1);
        check("f_rd", cpu_bus_rd_data, 32'd0);
        check("f_wd0", {16'b0, words_done}, 32'd0);
        tick();
        check("f_addr1", bus_addr, 32'h20004);
        check("f_wd1", {16'b0, words_done}, 32'd1);
        tick();
        check("f_addr2", bus_addr, 32'h20008);
        check("f_data2", bus_wr_data, 32'h11223344);
        tick();
        check("f_done", {31'b0, done}, 32'd1);
        check("f_busy_d", {31'b0, busy}, 32'd0);
        check("f_wd3", {16'b0, words_done}, 32'd3);
        check("f_ab", {31'b0, aborted}, 32'd0);
        check("f_pt_addr", bus_addr, 32'hDEAD0000);
        check("f_pt_data", bus_wr_data, 32'h55);
        tick();
        check("f_done_off", {31'b0, done}, 32'd0);
        cpu_bus_wr_en = 1'b0;

        // 3: zero-length command
        do_start(32'h5000, 16'd0, 32'h77);
        check("z_done", {31'b0, done}, 32'd1);
        check("z_wen", {31'b0, bus_wr_en}, 32'd0);
        check("z_busy", {31'b0, busy}, 32'd0);
        check("z_wd", {16'b0, words_done}, 32'd0);
        tick();
        check("z_done_off", {31'b0, done}, 32'd0);

        // 4: abort on the 4th write of 10
        writes = 0;
        do_start(32'h1000, 16'd10, 32'hA5A5A5A5);
        for (int k = 0; k < 4; k++) begin
            if (bus_wr_en) writes++;
            check("ab_addr", bus_addr, 32'h1000 + 32'(4 * k));
            if (k == 3) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        check("ab_done", {31'b0, done}, 32'd1);
        check("ab_flag", {31'b0, aborted}, 32'd1);
        check("ab_wd", {16'b0, words_done}, 32'd4);
        check("ab_writes", writes, 32'd4);
        check("ab_wen", {31'b0, bus_wr_en}, 32'd0);
        tick();
        check("ab_done_off", {31'b0, done}, 32'd0);
        check("ab_hold", {31'b0, aborted}, 32'd1);
        abort = 1'b1;
        tick();
        check("ab_idle_busy", {31'b0, busy}, 32'd0);
        check("ab_idle_done", {31'b0, done}, 32'd0);
        abort = 1'b0;

        // 4b: abort coinciding with the final write completes normally
        do_start(32'h3000, 16'd2, 32'h1);
        check("abf_clr", {31'b0, aborted}, 32'd0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abf_done", {31'b0, done}, 32'd1);
        check("abf_flag", {31'b0, aborted}, 32'd0);
        check("abf_wd", {16'b0, words_done}, 32'd2);
        tick();

        // 5: address wrap
        do_start(32'hFFFFFFF8, 16'd3, 32'h9);
        check("w_addr0", bus_addr, 32'hFFFFFFF8);
        tick();
        check("w_addr1", bus_addr, 32'hFFFFFFFC);
        tick();
        check("w_addr2", bus_addr, 32'h00000000);
        check("w_wen2", {31'b0, bus_wr_en}, 32'd1);
        tick();
        check("w_done", {31'b0, done}, 32'd1);
        tick();

        // 6: reset mid-fill, then a fresh run ignoring a start during FILL
        do_start(32'h8000, 16'd5, 32'hBEEF);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("mr_busy", {31'b0, busy}, 32'd0);
        check("mr_wen", {31'b0, bus_wr_en}, 32'd0);
        check("mr_wd", {16'b0, words_done}, 32'd0);
        check("mr_done", {31'b0, done}, 32'd0);
        check("mr_addr", bus_addr, 32'hDEAD0000);
        tick();
        rst = 1'b0;
        tick();
        check("mr_nodone", {31'b0, done}, 32'd0);
        do_start(32'h9000, 16'd2, 32'h1234);
        start = 1'b1; dst_addr = 32'h0; len_words = 16'd7; fill_data = 32'hFFFF;
        check("ig_addr0", bus_addr, 32'h9000);
        tick();
        check("ig_addr1", bus_addr, 32'h9004);
        check("ig_data1", bus_wr_data, 32'h1234);
        tick();
        start = 1'b0;
        check("ig_done", {31'b0, done}, 32'd1);
        check("ig_wd", {16'b0, words_done}, 32'd2);
        tick();
        check("ig_idle", {31'b0, busy}, 32'd0);
        check("ig_done_off", {31'b0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
